// File: rtl/piradspi_cmd_arbiter.sv
// piradspi_cmd_arbiter: round-robin arbiter sharing one piradspi SPI engine
// between NUM_REQ command sources.
//
// A winner is picked in IDLE (scan from rr_ptr upward), its command is
// latched and offered to the engine in ISSUE, and its MOSI/MISO streams are
// routed to the engine through ISSUE and ACTIVE. The grant is released on
// engine completion, engine error, or watchdog expiry.
//
// Ports:
//   aclk, aresetn        clock, synchronous active-low reset
//   req_cmd/valid/ready  per-requester command handshake (ready is one-hot or zero)
//   req_mosi_*           per-requester MOSI stream, routed from the granted slot
//   req_miso_*           MISO stream; data broadcast, valid only on the granted bit
//   eng_cmd*             registered command handshake to the engine
//   eng_mosi_*/eng_miso_* engine-side streams (combinational pass-through)
//   command_completed    completion pulse from the engine
//   engine_error         error level from the engine
//   busy                 state != IDLE (registered)
//   grant_id             current or last granted requester
//   abort_pulse/cause    one-cycle abort indication; cause 0 = error, 1 = timeout
module piradspi_cmd_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned CMD_WIDTH      = 64,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned GID_W          = $clog2(NUM_REQ)
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic [NUM_REQ*CMD_WIDTH-1:0]    req_cmd,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_mosi_tdata,
  input  logic [NUM_REQ-1:0]              req_mosi_tvalid,
  output logic [NUM_REQ-1:0]              req_mosi_tready,
  output logic [DATA_WIDTH-1:0]           req_miso_tdata,
  output logic [NUM_REQ-1:0]              req_miso_tvalid,
  input  logic [NUM_REQ-1:0]              req_miso_tready,
  output logic [CMD_WIDTH-1:0]            eng_cmd,
  output logic                            eng_cmd_valid,
  input  logic                            eng_cmd_ready,
  output logic [DATA_WIDTH-1:0]           eng_mosi_tdata,
  output logic                            eng_mosi_tvalid,
  input  logic                            eng_mosi_tready,
  input  logic [DATA_WIDTH-1:0]           eng_miso_tdata,
  input  logic                            eng_miso_tvalid,
  output logic                            eng_miso_tready,
  input  logic                            command_completed,
  input  logic                            engine_error,
  output logic                            busy,
  output logic [GID_W-1:0]                grant_id,
  output logic                            abort_pulse,
  output logic                            abort_cause
);

  localparam int unsigned WD_W = 16;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WD_W-1:0] WD_MAX   = {WD_W{1'b1}};
  localparam logic [GID_W-1:0] LAST_ID = GID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_ACTIVE = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [GID_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [GID_W-1:0]       grant_q, grant_d;
  logic [CMD_WIDTH-1:0]   eng_cmd_q, eng_cmd_d;
  logic                   eng_cmd_valid_q, eng_cmd_valid_d;
  logic [WD_W-1:0]        wd_q, wd_d;
  logic                   abort_pulse_q, abort_pulse_d;
  logic                   abort_cause_q, abort_cause_d;
  logic                   busy_q, busy_d;

  logic                   win_found;
  logic [GID_W-1:0]       win_idx;
  logic [GID_W-1:0]       scan_idx;
  logic                   wd_expired;

  // Per-requester slices of the flattened command and MOSI data buses.
  logic [CMD_WIDTH-1:0]   cmd_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0]  mosi_arr [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign cmd_arr[k]  = req_cmd[k*CMD_WIDTH +: CMD_WIDTH];
    assign mosi_arr[k] = req_mosi_tdata[k*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin winner: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      scan_idx = GID_W'((32'(rr_ptr_q) + i) % NUM_REQ);
      if (!win_found && req_valid[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  assign wd_expired = (TIMEOUT_CYCLES != 32'd0) && (wd_q == WD_LIMIT);

  // Next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_d       = grant_q;
    eng_cmd_d     = eng_cmd_q;
    wd_d          = wd_q;
    abort_pulse_d = 1'b0;
    abort_cause_d = abort_cause_q;

    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          eng_cmd_d = cmd_arr[win_idx];
          grant_d   = win_idx;
          rr_ptr_d  = (win_idx == LAST_ID) ? '0 : win_idx + GID_W'(1);
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // Completion pulses here belong to nothing we issued; ignore them.
        if (eng_cmd_ready) begin
          state_d = ST_ACTIVE;
          wd_d    = '0;
        end
      end
      ST_ACTIVE: begin
        wd_d = (wd_q == WD_MAX) ? wd_q : wd_q + WD_W'(1);
        if (engine_error) begin
          state_d       = ST_IDLE;
          abort_pulse_d = 1'b1;
          abort_cause_d = 1'b0;
        end else if (command_completed) begin
          state_d = ST_IDLE;
        end else if (wd_expired) begin
          state_d       = ST_IDLE;
          abort_pulse_d = 1'b1;
          abort_cause_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    eng_cmd_valid_d = (state_d == ST_ISSUE);
    busy_d          = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q         <= ST_IDLE;
      rr_ptr_q        <= '0;
      grant_q         <= '0;
      eng_cmd_q       <= '0;
      eng_cmd_valid_q <= 1'b0;
      wd_q            <= '0;
      abort_pulse_q   <= 1'b0;
      abort_cause_q   <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      rr_ptr_q        <= rr_ptr_d;
      grant_q         <= grant_d;
      eng_cmd_q       <= eng_cmd_d;
      eng_cmd_valid_q <= eng_cmd_valid_d;
      wd_q            <= wd_d;
      abort_pulse_q   <= abort_pulse_d;
      abort_cause_q   <= abort_cause_d;
      busy_q          <= busy_d;
    end
  end

  // Command acceptance and stream routing. Everything is masked while reset
  // is asserted so no handshake completes that the registers would not see.
  always_comb begin
    req_ready       = '0;
    req_mosi_tready = '0;
    req_miso_tvalid = '0;
    eng_mosi_tdata  = '0;
    eng_mosi_tvalid = 1'b0;
    eng_miso_tready = 1'b0;
    if (aresetn) begin
      if (state_q == ST_IDLE) begin
        if (win_found) begin
          req_ready[win_idx] = 1'b1;
        end
      end else begin
        eng_mosi_tdata           = mosi_arr[grant_q];
        eng_mosi_tvalid          = req_mosi_tvalid[grant_q];
        req_mosi_tready[grant_q] = eng_mosi_tready;
        req_miso_tvalid[grant_q] = eng_miso_tvalid;
        eng_miso_tready          = req_miso_tready[grant_q];
      end
    end
  end

  assign req_miso_tdata = eng_miso_tdata;
  assign eng_cmd        = eng_cmd_q;
  assign eng_cmd_valid  = eng_cmd_valid_q;
  assign busy           = busy_q;
  assign grant_id       = grant_q;
  assign abort_pulse    = abort_pulse_q;
  assign abort_cause    = abort_cause_q;

endmodule

// File: tb/tb_piradspi_cmd_arbiter.sv
// Testbench for piradspi_cmd_arbiter (NUM_REQ=4, TIMEOUT_CYCLES=16).
// Table-driven transactions, hand-written back-to-back and reset sequences,
// then randomized transactions checked against a transaction-level model.
module tb_piradspi_cmd_arbiter;

  localparam int N  = 4;
  localparam int CW = 64;
  localparam int DW = 32;
  localparam int TO = 16;

  logic              aclk = 1'b0;
  logic              aresetn;
  logic [N*CW-1:0]   req_cmd;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*DW-1:0]   req_mosi_tdata;
  logic [N-1:0]      req_mosi_tvalid;
  logic [N-1:0]      req_mosi_tready;
  logic [DW-1:0]     req_miso_tdata;
  logic [N-1:0]      req_miso_tvalid;
  logic [N-1:0]      req_miso_tready;
  logic [CW-1:0]     eng_cmd;
  logic              eng_cmd_valid;
  logic              eng_cmd_ready;
  logic [DW-1:0]     eng_mosi_tdata;
  logic              eng_mosi_tvalid;
  logic              eng_mosi_tready;
  logic [DW-1:0]     eng_miso_tdata;
  logic              eng_miso_tvalid;
  logic              eng_miso_tready;
  logic              command_completed;
  logic              engine_error;
  logic              busy;
  logic [1:0]        grant_id;
  logic              abort_pulse;
  logic              abort_cause;

  piradspi_cmd_arbiter #(
    .NUM_REQ(N), .CMD_WIDTH(CW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_cmd(req_cmd), .req_valid(req_valid), .req_ready(req_ready),
    .req_mosi_tdata(req_mosi_tdata), .req_mosi_tvalid(req_mosi_tvalid),
    .req_mosi_tready(req_mosi_tready),
    .req_miso_tdata(req_miso_tdata), .req_miso_tvalid(req_miso_tvalid),
    .req_miso_tready(req_miso_tready),
    .eng_cmd(eng_cmd), .eng_cmd_valid(eng_cmd_valid), .eng_cmd_ready(eng_cmd_ready),
    .eng_mosi_tdata(eng_mosi_tdata), .eng_mosi_tvalid(eng_mosi_tvalid),
    .eng_mosi_tready(eng_mosi_tready),
    .eng_miso_tdata(eng_miso_tdata), .eng_miso_tvalid(eng_miso_tvalid),
    .eng_miso_tready(eng_miso_tready),
    .command_completed(command_completed), .engine_error(engine_error),
    .busy(busy), .grant_id(grant_id), .abort_pulse(abort_pulse),
    .abort_cause(abort_cause)
  );

  always #5 aclk = ~aclk;

  // Outcome kinds: 0 complete, 1 error, 2 timeout, 3 error+complete together.
  typedef struct {
    logic [3:0] mask;
    logic [3:0] exp_ready;
    int         acc;
    int         kind;
    int         ev;
  } vec_t;

  vec_t        vecs [8];
  logic [CW-1:0] cmd_tab [N];
  int          pass_cnt = 0;
  int          chk_cnt  = 0;
  int          rr_m     = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic load_cmds();
    req_cmd = {cmd_tab[3], cmd_tab[2], cmd_tab[1], cmd_tab[0]};
  endtask

  task automatic drive_streams();
    req_mosi_tvalid = 4'($urandom);
    req_mosi_tdata  = {$urandom, $urandom, $urandom, $urandom};
    eng_mosi_tready = 1'($urandom);
    eng_miso_tvalid = 1'($urandom);
    eng_miso_tdata  = $urandom;
    req_miso_tready = 4'($urandom);
  endtask

  task automatic check_streams(input int g);
    logic [N*DW-1:0] d;
    d = req_mosi_tdata;
    check("mosi_data", eng_mosi_tdata, d[g*DW +: DW]);
    check("mosi_valid", eng_mosi_tvalid, req_mosi_tvalid[g]);
    check("mosi_ready", req_mosi_tready, eng_mosi_tready ? (64'd1 << g) : 64'd0);
    check("miso_valid", req_miso_tvalid, eng_miso_tvalid ? (64'd1 << g) : 64'd0);
    check("miso_ready", eng_miso_tready, req_miso_tready[g]);
    check("miso_data", req_miso_tdata, eng_miso_tdata);
  endtask

  task automatic check_idle_streams();
    check("idle_mosi_valid", eng_mosi_tvalid, 0);
    check("idle_mosi_data", eng_mosi_tdata, 0);
    check("idle_mosi_ready", req_mosi_tready, 0);
    check("idle_miso_valid", req_miso_tvalid, 0);
    check("idle_miso_ready", eng_miso_tready, 0);
  endtask

  function automatic int model_winner(input logic [3:0] m, input int rr);
    for (int i = 0; i < N; i++) if (m[(rr + i) % N]) return (rr + i) % N;
    return -1;
  endfunction

  // One full transaction starting in an IDLE cycle.
  task automatic do_txn(input logic [3:0] mask, input int exp_w, input int acc,
                        input int kind, input int ev);
    int n;
    logic [CW-1:0] exp_cmd;
    exp_cmd = cmd_tab[exp_w];
    req_valid = mask; eng_cmd_ready = 1'b0;
    command_completed = 1'b0; engine_error = 1'b0;
    drive_streams();
    #2;
    check("idle_busy", busy, 0);
    check("idle_pulse", abort_pulse, 0);
    check("req_ready", req_ready, 64'd1 << exp_w);
    check_idle_streams();
    step();
    for (int c = 0; c <= acc; c++) begin
      eng_cmd_ready = (c == acc);
      command_completed = (c < acc) ? 1'($urandom) : 1'b0;
      drive_streams();
      #2;
      check("issue_valid", eng_cmd_valid, 1);
      check("issue_cmd", eng_cmd, exp_cmd);
      check("issue_gid", grant_id, exp_w);
      check("issue_busy", busy, 1);
      check("issue_rdy", req_ready, 0);
      check_streams(exp_w);
      step();
    end
    eng_cmd_ready = 1'b0; command_completed = 1'b0;
    n = (kind == 2) ? TO : ev + 1;
    for (int t = 0; t < n; t++) begin
      drive_streams();
      if (t == n - 1 && kind != 2) begin
        engine_error      = (kind == 1 || kind == 3);
        command_completed = (kind == 0 || kind == 3);
      end
      #2;
      check("act_busy", busy, 1);
      check("act_cmdv", eng_cmd_valid, 0);
      check("act_rdy", req_ready, 0);
      check_streams(exp_w);
      step();
    end
    engine_error = 1'b0; command_completed = 1'b0; req_valid = '0;
    drive_streams();
    #2;
    check("end_busy", busy, 0);
    check("end_pulse", abort_pulse, (kind != 0));
    if (kind != 0) check("end_cause", abort_cause, (kind == 2));
    check("end_gid", grant_id, exp_w);
    check_idle_streams();
    rr_m = (exp_w + 1) % N;
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    int w;
    vecs[0] = '{4'b0100, 4'b0100, 0, 0, 0};
    vecs[1] = '{4'b0111, 4'b0001, 1, 2, 0};
    vecs[2] = '{4'b1111, 4'b0010, 2, 1, 3};
    vecs[3] = '{4'b1001, 4'b1000, 0, 3, 2};
    vecs[4] = '{4'b1000, 4'b1000, 3, 0, 5};
    vecs[5] = '{4'b0011, 4'b0001, 0, 2, 0};
    vecs[6] = '{4'b0001, 4'b0001, 0, 0, 15};
    vecs[7] = '{4'b1010, 4'b0010, 1, 1, 15};
    cmd_tab[0] = 64'h1111_0000_0000_0001;
    cmd_tab[1] = 64'h2222_0000_0000_0002;
    cmd_tab[2] = 64'h0000_0000_0000_00A5;
    cmd_tab[3] = 64'h4444_0000_0000_0004;
    load_cmds();

    aresetn = 1'b0; req_valid = '0; eng_cmd_ready = 1'b0;
    command_completed = 1'b0; engine_error = 1'b0;
    req_mosi_tvalid = '0; req_mosi_tdata = '0; eng_mosi_tready = 1'b0;
    eng_miso_tvalid = 1'b0; eng_miso_tdata = '0; req_miso_tready = '0;
    step(); step();
    aresetn = 1'b1;
    #2;
    check("rst_busy", busy, 0);
    check("rst_cmd", eng_cmd, 0);
    check("rst_cmdv", eng_cmd_valid, 0);
    check("rst_gid", grant_id, 0);
    check("rst_pulse", abort_pulse, 0);
    check("rst_cause", abort_cause, 0);
    check("rst_rdy", req_ready, 0);
    check_idle_streams();
    step();

    // Table-driven transactions.
    for (int i = 0; i < 8; i++) begin
      w = 0;
      for (int k = 0; k < N; k++) if (vecs[i].exp_ready[k]) w = k;
      do_txn(vecs[i].mask, w, vecs[i].acc, vecs[i].kind, vecs[i].ev);
    end

    // Reset in the middle of ACTIVE; rr_ptr is 2 here.
    req_valid = 4'hF;
    #2;
    check("rstseq_rdy", req_ready, 4'b0100);
    step();
    eng_cmd_ready = 1'b1;
    #2; step();
    eng_cmd_ready = 1'b0;
    #2;
    check("rstseq_busy", busy, 1);
    step();
    aresetn = 1'b0;
    #2;
    check("rstseq_rdy_in_rst", req_ready, 0);
    step();
    aresetn = 1'b1; req_valid = '0;
    #2;
    check("rstseq_busy0", busy, 0);
    check("rstseq_cmd0", eng_cmd, 0);
    check("rstseq_cmdv0", eng_cmd_valid, 0);
    check("rstseq_gid0", grant_id, 0);
    check("rstseq_pulse0", abort_pulse, 0);
    check_idle_streams();
    step();

    // Back-to-back round robin with every requester held valid.
    req_valid = 4'hF;
    for (int i = 0; i < 8; i++) begin
      #2;
      check("rr_ready", req_ready, 64'd1 << (i % N));
      check("rr_busy_idle", busy, 0);
      step();
      eng_cmd_ready = 1'b1;
      #2;
      check("rr_cmdv", eng_cmd_valid, 1);
      check("rr_gid", grant_id, i % N);
      check("rr_cmd", eng_cmd, cmd_tab[i % N]);
      step();
      eng_cmd_ready = 1'b0; command_completed = 1'b1;
      #2; step();
      command_completed = 1'b0;
    end
    req_valid = '0;
    #2;
    check("rr_end_pulse", abort_pulse, 0);
    step();
    rr_m = 0;

    // Randomized transactions against the round-robin model.
    for (int i = 0; i < 40; i++) begin
      logic [3:0] m;
      for (int k = 0; k < N; k++) cmd_tab[k] = {$urandom, $urandom};
      load_cmds();
      m = 4'($urandom_range(1, 15));
      w = model_winner(m, rr_m);
      do_txn(m, w, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 15));
    end
    #2;
    check("final_pulse", abort_pulse, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
